result_log_arbiter: RTL and testbench
=====================================

Name: result_log_arbiter

Overview:
- Hardware scoreboard and log scheduler for self-checking simulation and FPGA benches.
- Shares one log/trace output port among NUM_REQ checker units using round-robin arbitration.
- Filters each result by verbosity against a runtime threshold and keeps pass/fail counters, the hardware counterpart of the team's test_stats record.
- Sits between the datapath checkers and the single trace sink (UART/trace buffer).

Parameters:
- NUM_REQ, 4, number of checker requesters; 2..16.
- CODE_W, 8, width of the per-result message code.
- VERB_W, 10, verbosity field width; holds the levels 0/100/200/300/400/500.
- CNT_W, 32, width of the pass and fail counters.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_verbosity  in  VERB_W  threshold; a result is forwarded iff req_verb <= cfg_verbosity.
- clr  in  1  synchronous clear of counters and saturation flags.
- req_valid  in  NUM_REQ  per-requester result valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_pass  in  NUM_REQ  per-requester result: 1 = pass, 0 = fail.
- req_verb  in  NUM_REQ*VERB_W  packed per-requester verbosity; requester i uses bits [i*VERB_W +: VERB_W].
- req_code  in  NUM_REQ*CODE_W  packed per-requester message code.
- log_valid  out  1  forwarded entry valid.
- log_ready  in  1  sink accepts the entry.
- log_src  out  $clog2(NUM_REQ)  index of the requester that produced the entry.
- log_pass  out  1  pass/fail bit of the entry.
- log_code  out  CODE_W  code of the entry.
- pass_cnt  out  CNT_W  total accepted passes.
- fail_cnt  out  CNT_W  total accepted fails.
- cnt_sat  out  1  sticky; set when either counter saturates.
- busy  out  1  high when log_valid is high or any req_valid is high.

Behaviour:
- Reset (rst_n low, async): log_valid=0, log_src/log_pass/log_code=0, pass_cnt=fail_cnt=0, cnt_sat=0, RR pointer=0 (requester 0 has top priority), req_ready=0.
- Output slot is a single register with states EMPTY and FULL.
  - slot_free = EMPTY, or (FULL and log_ready).
- Grant is combinational.
  - When slot_free, grant the first req_valid found searching from the RR pointer upward with wrap-around.
  - req_ready is driven for that index only. Otherwise req_ready=0.
- On accept (req_valid[i] and req_ready[i]):
  - RR pointer becomes (i+1) mod NUM_REQ.
  - Counters update at the next edge: pass_cnt+1 if req_pass, else fail_cnt+1.
  - If req_verb[i] <= cfg_verbosity, the slot loads {i, pass, code} and log_valid=1 from the next cycle (latency 1).
  - Otherwise the result is counted but not forwarded; the slot goes EMPTY if it was draining.
- FULL with log_ready=0: log_* outputs hold stable; no grants are issued.
- FULL with log_ready=1 and a new accept in the same cycle: back-to-back refill, giving one entry per cycle throughput.
- FULL with log_ready=1 and no accept: the slot becomes EMPTY and log_valid=0 next cycle.
- Verbosity compare is unsigned on VERB_W bits. cfg_verbosity=0 forwards only VERB_NONE results. cfg_verbosity=all-ones forwards everything.
- Counters saturate at 2^CNT_W-1. A further increment of a saturated counter holds its value and sets cnt_sat; cnt_sat clears only via clr or reset.
- clr has priority over an accept in the same cycle:
  - Counters and cnt_sat become 0, and that event is not counted.
  - Forwarding of that event proceeds normally.
  - clr does not affect the slot or the RR pointer.
- cfg_verbosity is sampled in the accept cycle only; changing it has no effect on an entry already in the slot.
- Requesters must hold req_valid and payload until accepted. The arbiter never drops an accepted result.
- Reset asserted mid-transfer discards any pending entry immediately (async).

Test Plan:
- Single requester: req 2 sends pass, verb 100, code 0x5A, cfg 200, log_ready=1. Expect log_valid one cycle after accept with src=2, pass=1, code=0x5A, pass_cnt=1, fail_cnt=0.
- Fairness: all 4 requesters hold valid, log_ready=1 for 8 cycles. Expect grants in order 0,1,2,3,0,1,2,3, one per cycle, and total counts = 8.
- Filtering: cfg=100; requesters send verb 0, 200, 100 (fail, pass, fail). Expect only the verb-0 and verb-100 entries on the log port, fail_cnt=2, pass_cnt=1.
- Backpressure: log_ready=0 for 5 cycles with req 1 valid. Expect req_ready=0 and log_* stable. Raise log_ready; expect req 1 to be accepted in the same cycle.
- Saturation/clear with CNT_W=4: send 16 passes. Expect pass_cnt=15 and cnt_sat=1. Pulse clr together with a fail accept; expect fail_cnt=0, pass_cnt=0, cnt_sat=0, and the fail entry still logged.
- Reset mid-operation: drop rst_n while log_valid=1. Expect all outputs 0 immediately; after release, requester 0 wins first when all are valid.

Source files
------------

// File: rtl/result_log_arbiter.sv
// Round-robin log port arbiter with verbosity filtering and saturating
// pass/fail counters shared by NUM_REQ checker units.
module result_log_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CODE_W  = 8,
   parameter int VERB_W  = 10,
   parameter int CNT_W   = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [VERB_W-1:0]            cfg_verbosity,
   input  logic                         clr,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0]           req_pass,
   input  logic [NUM_REQ*VERB_W-1:0]    req_verb,
   input  logic [NUM_REQ*CODE_W-1:0]    req_code,
   output logic                         log_valid,
   input  logic                         log_ready,
   output logic [$clog2(NUM_REQ)-1:0]   log_src,
   output logic                         log_pass,
   output logic [CODE_W-1:0]            log_code,
   output logic [CNT_W-1:0]             pass_cnt,
   output logic [CNT_W-1:0]             fail_cnt,
   output logic                         cnt_sat,
   output logic                         busy
);

   localparam int SRC_W = $clog2(NUM_REQ);

   typedef enum logic {EMPTY, FULL} slot_e;

   slot_e               state_q, state_d;
   logic [SRC_W-1:0]    ptr_q, ptr_d;
   logic [SRC_W-1:0]    src_q, src_d;
   logic                pass_q, pass_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [CNT_W-1:0]    pc_q, pc_d;
   logic [CNT_W-1:0]    fc_q, fc_d;
   logic                sat_q, sat_d;

   logic [SRC_W-1:0]    gnt;
   logic                found;
   logic                slot_free;
   logic                accept;
   logic                fwd;
   logic                g_pass;
   logic [VERB_W-1:0]   g_verb;
   logic [CODE_W-1:0]   g_code;

   // Two passes: indices at or above the pointer first, then wrap to 0.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i] && (SRC_W'(i) >= ptr_q)) begin
            found = 1'b1;
            gnt   = SRC_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            gnt   = SRC_W'(i);
         end
      end
   end

   always_comb begin
      g_pass = 1'b0;
      g_verb = '0;
      g_code = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt == SRC_W'(i)) begin
            g_pass = req_pass[i];
            g_verb = req_verb[i*VERB_W +: VERB_W];
            g_code = req_code[i*CODE_W +: CODE_W];
         end
      end
   end

   assign slot_free = (state_q == EMPTY) || log_ready;
   assign accept    = found && slot_free;
   assign fwd       = accept && (g_verb <= cfg_verbosity);
   assign req_ready = (accept && rst_n) ? (NUM_REQ'(1) << gnt) : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      src_d   = src_q;
      pass_d  = pass_q;
      code_d  = code_q;
      if (accept) begin
         ptr_d = (gnt == SRC_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
      end
      if (fwd) begin
         state_d = FULL;
         src_d   = gnt;
         pass_d  = g_pass;
         code_d  = g_code;
      end else if (log_ready) begin
         state_d = EMPTY;
      end
   end

   // A saturated counter holds its value and raises the sticky flag.
   always_comb begin
      pc_d  = pc_q;
      fc_d  = fc_q;
      sat_d = sat_q;
      if (clr) begin
         pc_d  = '0;
         fc_d  = '0;
         sat_d = 1'b0;
      end else if (accept) begin
         if (g_pass) begin
            if (&pc_q) sat_d = 1'b1;
            else       pc_d  = pc_q + 1'b1;
         end else begin
            if (&fc_q) sat_d = 1'b1;
            else       fc_d  = fc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         src_q   <= '0;
         pass_q  <= 1'b0;
         code_q  <= '0;
         pc_q    <= '0;
         fc_q    <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         src_q   <= src_d;
         pass_q  <= pass_d;
         code_q  <= code_d;
         pc_q    <= pc_d;
         fc_q    <= fc_d;
         sat_q   <= sat_d;
      end
   end

   assign log_valid = (state_q == FULL);
   assign log_src   = src_q;
   assign log_pass  = pass_q;
   assign log_code  = code_q;
   assign pass_cnt  = pc_q;
   assign fail_cnt  = fc_q;
   assign cnt_sat   = sat_q;
   assign busy      = log_valid || (|req_valid);

endmodule

// File: tb/tb_result_log_arbiter.sv
// Directed vector bench for result_log_arbiter (4 requesters, 4-bit counters).
module tb_result_log_arbiter;

   localparam int N  = 4;
   localparam int CW = 8;
   localparam int VW = 10;
   localparam int KW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [VW-1:0]   cfg_verbosity;
   logic            clr;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_pass;
   logic [N*VW-1:0] req_verb;
   logic [N*CW-1:0] req_code;
   logic            log_valid;
   logic            log_ready;
   logic [1:0]      log_src;
   logic            log_pass;
   logic [CW-1:0]   log_code;
   logic [KW-1:0]   pass_cnt;
   logic [KW-1:0]   fail_cnt;
   logic            cnt_sat;
   logic            busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   result_log_arbiter #(
      .NUM_REQ(N), .CODE_W(CW), .VERB_W(VW), .CNT_W(KW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_verbosity(cfg_verbosity), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_pass(req_pass),
      .req_verb(req_verb), .req_code(req_code), .log_valid(log_valid),
      .log_ready(log_ready), .log_src(log_src), .log_pass(log_pass),
      .log_code(log_code), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .cnt_sat(cnt_sat), .busy(busy)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  pas;
      logic [39:0] verb;
      logic [31:0] code;
      logic [9:0]  cfg;
      logic        lr;
      logic        clr;
      logic [3:0]  rdy;
      logic        lv;
      logic [1:0]  src;
      logic        lp;
      logic [7:0]  lc;
      logic [3:0]  pc;
      logic [3:0]  fc;
      logic        sat;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic run_vec(input vec_t v, input int k);
      req_valid     = v.vld;
      req_pass      = v.pas;
      req_verb      = v.verb;
      req_code      = v.code;
      cfg_verbosity = v.cfg;
      log_ready     = v.lr;
      clr           = v.clr;
      #1;
      chk($sformatf("v%0d req_ready", k), 64'(req_ready), 64'(v.rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d log_valid", k), 64'(log_valid), 64'(v.lv));
      if (v.lv) begin
         chk($sformatf("v%0d log_src", k), 64'(log_src), 64'(v.src));
         chk($sformatf("v%0d log_pass", k), 64'(log_pass), 64'(v.lp));
         chk($sformatf("v%0d log_code", k), 64'(log_code), 64'(v.lc));
      end
      chk($sformatf("v%0d pass_cnt", k), 64'(pass_cnt), 64'(v.pc));
      chk($sformatf("v%0d fail_cnt", k), 64'(fail_cnt), 64'(v.fc));
      chk($sformatf("v%0d cnt_sat", k), 64'(cnt_sat), 64'(v.sat));
   endtask

   task automatic idle();
      req_valid = '0;
      clr       = 1'b0;
      log_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0;
      cfg_verbosity = 10'd200;
      clr = 1'b0;
      req_valid = '0;
      req_pass = '0;
      req_verb = '0;
      req_code = '0;
      log_ready = 1'b1;

      // Fairness: all four hold valid, expect 0,1,2,3,0,1,2,3.
      for (int k = 0; k < 8; k++) begin
         v = '{4'hF, 4'hF, 40'd0, 32'h13121110, 10'd200, 1'b1, 1'b0,
               4'(1 << (k % 4)), 1'b1, 2'(k % 4), 1'b1, 8'(8'h10 + k % 4),
               4'(k + 1), 4'd0, 1'b0};
         tv.push_back(v);
      end
      tv.push_back('{4'h0, 4'h0, 40'd0, 32'd0, 10'd200, 1'b1, 1'b1,
                     4'h0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0});
      // Single requester 2: pass, verb 100, code 5A, cfg 200.
      tv.push_back('{4'h4, 4'h4, {10'd0, 10'd100, 10'd0, 10'd0},
                     32'h005A0000, 10'd200, 1'b1, 1'b0,
                     4'h4, 1'b1, 2'd2, 1'b1, 8'h5A, 4'd1, 4'd0, 1'b0});
      tv.push_back('{4'h0, 4'h0, 40'd0, 32'd0, 10'd200, 1'b1, 1'b1,
                     4'h0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0});
      // Filtering, cfg 100: r0 verb0 fail, r1 verb200 pass, r2 verb100 fail.
      tv.push_back('{4'h7, 4'h2, {10'd0, 10'd100, 10'd200, 10'd0},
                     32'h00A2A1A0, 10'd100, 1'b1, 1'b0,
                     4'h1, 1'b1, 2'd0, 1'b0, 8'hA0, 4'd0, 4'd1, 1'b0});
      tv.push_back('{4'h6, 4'h2, {10'd0, 10'd100, 10'd200, 10'd0},
                     32'h00A2A1A0, 10'd100, 1'b1, 1'b0,
                     4'h2, 1'b0, 2'd0, 1'b0, 8'h00, 4'd1, 4'd1, 1'b0});
      tv.push_back('{4'h4, 4'h2, {10'd0, 10'd100, 10'd200, 10'd0},
                     32'h00A2A1A0, 10'd100, 1'b1, 1'b0,
                     4'h4, 1'b1, 2'd2, 1'b0, 8'hA2, 4'd1, 4'd2, 1'b0});
      tv.push_back('{4'h0, 4'h0, 40'd0, 32'd0, 10'd100, 1'b1, 1'b0,
                     4'h0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd1, 4'd2, 1'b0});

      // Reset state.
      #12;
      chk("reset log_valid", 64'(log_valid), 64'd0);
      chk("reset req_ready", 64'(req_ready), 64'd0);
      chk("reset pass_cnt", 64'(pass_cnt), 64'd0);
      chk("reset cnt_sat", 64'(cnt_sat), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle busy", 64'(busy), 64'd0);

      foreach (tv[i]) run_vec(tv[i], i);

      // Backpressure: RR pointer is at 3 here; park r3 in the slot.
      cfg_verbosity = 10'd100;
      req_valid = 4'h8;
      req_pass  = 4'hF;
      req_verb  = '0;
      req_code  = 32'hB3B2B1B0;
      log_ready = 1'b0;
      #1;
      chk("bp load ready", 64'(req_ready), 64'h8);
      @(posedge clk); #1;
      chk("bp load src", 64'(log_src), 64'd3);
      req_valid = 4'h2;
      req_pass  = 4'h0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp%0d ready", c), 64'(req_ready), 64'h0);
         @(posedge clk); #1;
         chk($sformatf("bp%0d log_valid", c), 64'(log_valid), 64'd1);
         chk($sformatf("bp%0d log_src", c), 64'(log_src), 64'd3);
         chk($sformatf("bp%0d log_code", c), 64'(log_code), 64'hB3);
      end
      log_ready = 1'b1;
      #1;
      chk("bp release ready", 64'(req_ready), 64'h2);
      @(posedge clk); #1;
      chk("bp refill src", 64'(log_src), 64'd1);
      chk("bp refill code", 64'(log_code), 64'hB1);
      chk("bp refill pass", 64'(log_pass), 64'd0);
      chk("bp fail_cnt", 64'(fail_cnt), 64'd3);

      // Saturation with 4-bit counters, then clr with a fail accept.
      req_valid = '0;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      req_valid = 4'h1;
      req_pass  = 4'h1;
      req_code  = 32'h00000077;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
      end
      chk("sat pass_cnt", 64'(pass_cnt), 64'd15);
      chk("sat cnt_sat", 64'(cnt_sat), 64'd1);
      req_pass = 4'h0;
      req_code = 32'h00000066;
      clr = 1'b1;
      #1;
      chk("clr ready", 64'(req_ready), 64'h1);
      @(posedge clk); #1;
      clr = 1'b0;
      req_valid = '0;
      chk("clr pass_cnt", 64'(pass_cnt), 64'd0);
      chk("clr fail_cnt", 64'(fail_cnt), 64'd0);
      chk("clr cnt_sat", 64'(cnt_sat), 64'd0);
      chk("clr log_valid", 64'(log_valid), 64'd1);
      chk("clr log_code", 64'(log_code), 64'h66);
      chk("clr log_pass", 64'(log_pass), 64'd0);
      idle();

      // Reset mid-operation with a full slot and pointer at 2.
      log_ready = 1'b0;
      req_valid = 4'h2;
      req_pass  = 4'h2;
      req_code  = 32'h00005500;
      @(posedge clk); #1;
      chk("pre-rst log_valid", 64'(log_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      req_valid = '0;
      #1;
      chk("rst log_valid", 64'(log_valid), 64'd0);
      chk("rst log_src", 64'(log_src), 64'd0);
      chk("rst log_pass", 64'(log_pass), 64'd0);
      chk("rst log_code", 64'(log_code), 64'd0);
      chk("rst pass_cnt", 64'(pass_cnt), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      req_valid = 4'hF;
      req_pass  = 4'hF;
      log_ready = 1'b1;
      #1;
      chk("post-rst ready", 64'(req_ready), 64'h1);
      @(posedge clk); #1;
      chk("post-rst log_src", 64'(log_src), 64'd0);
      req_valid = '0;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
